// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage. Owns the PC, keeps at most one
// imem read in flight and presents pc/instr to the IF/ID register.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] buf_instr;
  logic [31:0] buf_n;
  logic        drop;
  logic        drop_n;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  assign tgt    = {redirect_pc[31:2], 2'b00};
  assign pc_inc = pc + 32'd4;

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    buf_n          = buf_instr;
    drop_n         = drop;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc;
    if_valid       = 1'b0;
    if_pc          = 32'h0;
    if_instr       = 32'h0;
    unique case (state)
      BOOT: state_n = REQ;
      REQ: begin
        imem_req_valid = 1'b1;
        if (redirect_valid) pc_n = tgt;
        // a request accepted under a redirect fetches the wrong path
        if (imem_req_ready) begin
          state_n = WAIT;
          drop_n  = redirect_valid;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n = tgt;
          if (imem_rsp_valid) begin
            state_n = REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          drop_n  = 1'b0;
          state_n = REQ;
          if (!drop) begin
            if_valid = 1'b1;
            if_pc    = pc;
            if_instr = imem_rsp_data;
            if (stall) begin
              buf_n   = imem_rsp_data;
              state_n = HOLD;
            end else begin
              pc_n    = pc_inc;
            end
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          state_n = REQ;
        end else begin
          if_valid = 1'b1;
          if_pc    = pc;
          if_instr = buf_instr;
          if (!stall) begin
            pc_n    = pc_inc;
            state_n = REQ;
          end
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      buf_instr <= 32'h0;
      drop      <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      buf_instr <= buf_n;
      drop      <= drop_n;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed cycle checks plus a randomized run
// against a transaction-level fetch model with a latency memory.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // memory: answers each accepted request after mem_lat cycles
  bit          hs_q;
  bit          rst_q;
  bit          pend = 1'b0;
  int          cnt;
  logic [31:0] a_q;
  logic [31:0] paddr;
  always begin
    @(negedge clk);
    hs_q  = imem_req_valid && imem_req_ready;
    a_q   = imem_req_addr;
    rst_q = rst;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (rst_q) begin
      pend = 1'b0;
    end else begin
      if (hs_q) begin
        pend  = 1'b1;
        cnt   = mem_lat;
        paddr = a_q;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend           = 1'b0;
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mem_lat = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_req_valid got=%0b want=0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_err++;
      $display("FAIL rst_req_addr got=%h want=%h", imem_req_addr, RESET_PC); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_if_valid got=%0b want=0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++;
      $display("FAIL rst_if_pc got=%h want=0", if_pc); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++;
      $display("FAIL rst_if_instr got=%h want=0", if_instr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++;
      $display("FAIL boot_req_valid got=%0b want=0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_err++;
      $display("FAIL boot_req_addr got=%h want=%h", imem_req_addr, RESET_PC); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++;
      $display("FAIL boot_if_valid got=%0b want=0", if_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (c % 2 == 1) begin
        e = RESET_PC + 32'(4 * ((c - 1) / 2));
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin
          n_err++; $display("FAIL stream_req c=%0d got=%0b/%h want=1/%h",
            c, imem_req_valid, imem_req_addr, e); end
        n_cmp++; if (if_valid !== 1'b0) begin n_err++;
          $display("FAIL stream_bubble c=%0d got=%0b want=0", c, if_valid); end
      end else begin
        e = RESET_PC + 32'(4 * (c / 2 - 1));
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== e) begin n_err++;
          $display("FAIL stream_if c=%0d got=%0b/%h want=1/%h",
            c, if_valid, if_pc, e); end
        n_cmp++; if (if_instr !== mem_word(e)) begin n_err++;
          $display("FAIL stream_instr c=%0d got=%h want=%h",
            c, if_instr, mem_word(e)); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    mem_lat = 1;
    do_reset();
    e = RESET_PC + 32'd4;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      stall = (c >= 4 && c <= 6);
      @(negedge clk);
      if (c >= 4 && c <= 7) begin
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== e
                     || if_instr !== mem_word(e)) begin n_err++;
          $display("FAIL stall_hold c=%0d got=%0b/%h/%h want=1/%h/%h",
            c, if_valid, if_pc, if_instr, e, mem_word(e)); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++;
          $display("FAIL stall_noreq c=%0d got=%0b want=0",
            c, imem_req_valid); end
      end
      if (c == 8) begin
        n_cmp++; if (imem_req_valid !== 1'b1
                     || imem_req_addr !== RESET_PC + 32'd8) begin n_err++;
          $display("FAIL stall_next got=%0b/%h want=1/%h",
            imem_req_valid, imem_req_addr, RESET_PC + 32'd8); end
      end
    end
  endtask

  task automatic test_ready_low();
    mem_lat = 1;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      imem_req_ready = (c >= 5);
      @(negedge clk);
      if (c <= 4) begin
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC
                     || if_valid !== 1'b0) begin n_err++;
          $display("FAIL ready_low c=%0d got=%0b/%h/%0b want=1/%h/0",
            c, imem_req_valid, imem_req_addr, if_valid, RESET_PC); end
      end
      if (c == 6) begin
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin n_err++;
          $display("FAIL ready_rsp got=%0b/%h want=1/%h",
            if_valid, if_pc, RESET_PC); end
      end
    end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 2;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      redirect_valid = (c == 2);
      redirect_pc    = 32'h8000_0103;
      @(negedge clk);
      if (c == 2 || c == 3 || c == 5) begin
        n_cmp++; if (if_valid !== 1'b0) begin n_err++;
          $display("FAIL rdw_bubble c=%0d got=%0b want=0", c, if_valid); end
      end
      if (c == 4) begin
        n_cmp++; if (imem_req_valid !== 1'b1
                     || imem_req_addr !== 32'h8000_0100) begin n_err++;
          $display("FAIL rdw_req got=%0b/%h want=1/80000100",
            imem_req_valid, imem_req_addr); end
      end
      if (c == 6) begin
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0100
                     || if_instr !== mem_word(32'h8000_0100)) begin n_err++;
          $display("FAIL rdw_if got=%0b/%h/%h want=1/80000100/%h",
            if_valid, if_pc, if_instr, mem_word(32'h8000_0100)); end
      end
    end
    mem_lat = 1;
  endtask

  task automatic test_redirect_hold();
    mem_lat = 1;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      stall          = (c == 2 || c == 3 || c == 5);
      redirect_valid = (c == 3 || c == 5);
      redirect_pc    = (c == 3) ? 32'h8000_0200 : 32'h8000_0302;
      @(negedge clk);
      if (c == 2) begin
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin n_err++;
          $display("FAIL rdh_first got=%0b/%h want=1/%h",
            if_valid, if_pc, RESET_PC); end
      end
      if (c == 3 || c == 5) begin
        n_cmp++; if (if_valid !== 1'b0 || if_pc !== 32'h0
                     || if_instr !== 32'h0) begin n_err++;
          $display("FAIL rdh_kill c=%0d got=%0b/%h/%h want=0/0/0",
            c, if_valid, if_pc, if_instr); end
      end
      if (c == 4 || c == 6) begin
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !==
              ((c == 4) ? 32'h8000_0200 : 32'h8000_0300)) begin n_err++;
          $display("FAIL rdh_req c=%0d got=%0b/%h", c,
            imem_req_valid, imem_req_addr); end
      end
      if (c == 7) begin
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0300
                     || if_instr !== mem_word(32'h8000_0300)) begin n_err++;
          $display("FAIL rdh_if got=%0b/%h/%h want=1/80000300",
            if_valid, if_pc, if_instr); end
      end
    end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      redirect_valid = (c == 1);
      redirect_pc    = 32'hFFFF_FFFC;
      @(negedge clk);
      if (c == 2) begin
        n_cmp++; if (if_valid !== 1'b0) begin n_err++;
          $display("FAIL wrap_stale got=%0b want=0", if_valid); end
      end
      if (c == 3 || c == 5) begin
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !==
              ((c == 3) ? 32'hFFFF_FFFC : 32'h0)) begin n_err++;
          $display("FAIL wrap_req c=%0d got=%0b/%h", c,
            imem_req_valid, imem_req_addr); end
      end
      if (c == 4 || c == 6) begin
        n_cmp++; if (if_valid !== 1'b1 || if_pc !==
              ((c == 4) ? 32'hFFFF_FFFC : 32'h0)) begin n_err++;
          $display("FAIL wrap_if c=%0d got=%0b/%h", c, if_valid, if_pc); end
      end
      if (c == 6) begin
        n_cmp++; if (if_instr !== mem_word(32'h0)) begin n_err++;
          $display("FAIL wrap_instr got=%h want=%h",
            if_instr, mem_word(32'h0)); end
      end
    end
  endtask

  // model: expected next PC, one outstanding read (fresh or stale),
  // and whether an instruction is being held by a stall
  task automatic test_random();
    logic [31:0] exp_pc;
    bit          outst;
    bit          fresh;
    bit          hold;
    bit          rv;
    bit          hs;
    bit          exp_ifv;
    int          delivered;
    exp_pc    = RESET_PC;
    outst     = 1'b0;
    fresh     = 1'b0;
    hold      = 1'b0;
    delivered = 0;
    do_reset();
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk);
      #1;
      mem_lat        = $urandom_range(1, 3);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        redirect_pc = {16'h8000, 16'($urandom)};
      @(negedge clk);
      rv      = redirect_valid;
      hs      = imem_req_valid && imem_req_ready;
      exp_ifv = !rv && ((imem_rsp_valid && outst && fresh) || hold);
      n_cmp++; if (if_valid !== exp_ifv) begin n_err++;
        $display("FAIL rnd_valid c=%0d got=%0b want=%0b",
          c, if_valid, exp_ifv); end
      if (exp_ifv) begin
        n_cmp++; if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
          n_err++; $display("FAIL rnd_if c=%0d got=%h/%h want=%h/%h",
            c, if_pc, if_instr, exp_pc, mem_word(exp_pc)); end
      end else begin
        n_cmp++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin n_err++;
          $display("FAIL rnd_bubble c=%0d got=%h/%h want=0/0",
            c, if_pc, if_instr); end
      end
      if (hs) begin
        n_cmp++; if (outst || hold) begin n_err++;
          $display("FAIL rnd_one_out c=%0d got=req want=none", c); end
        if (!rv) begin
          n_cmp++; if (imem_req_addr !== exp_pc) begin n_err++;
            $display("FAIL rnd_addr c=%0d got=%h want=%h",
              c, imem_req_addr, exp_pc); end
        end
      end
      if (imem_rsp_valid && outst) outst = 1'b0;
      if (exp_ifv) begin
        if (stall) begin
          hold = 1'b1;
        end else begin
          hold      = 1'b0;
          exp_pc    = exp_pc + 32'd4;
          delivered++;
        end
      end
      if (hs) begin
        outst = 1'b1;
        fresh = !rv;
      end
      if (rv) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
        hold   = 1'b0;
        fresh  = 1'b0;
      end
    end
    n_cmp++; if (delivered < 200) begin n_err++;
      $display("FAIL rnd_progress got=%0d want>=200", delivered); end
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_ready_low();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage of the NPC pipeline. Owns the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and presents the fetched PC/instruction pair to the IF/ID pipeline register. Honours the hazard unit's `stall` and the EX-stage `redirect` (branch/jump/trap), discarding any in-flight or held instruction on the wrong path.

## Interface
- `RESET_PC`, 32'h8000_0000, first fetch address after reset

- `clk` input 1: clock
- `rst` input 1: reset, asynchronous, active-high
- `stall` input 1: IF/ID will not accept this cycle (same signal that feeds IF/ID)
- `redirect_valid` input 1: fetch must restart at `redirect_pc`
- `redirect_pc` input 32: new fetch address; bits [1:0] ignored and treated as 0
- `imem_req_valid` output 1: read request valid
- `imem_req_ready` input 1: memory accepts request
- `imem_req_addr` output 32: read address, word aligned
- `imem_rsp_valid` input 1: read data valid, one-cycle pulse
- `imem_rsp_data` input 32: instruction word
- `if_valid` output 1: `if_pc`/`if_instr` carry a real instruction
- `if_pc` output 32: PC of presented instruction
- `if_instr` output 32: presented instruction

## Operation
- Registers: `pc` (32), `state`, `buf_instr` (32), `drop` (1).
- States: BOOT, REQ, WAIT, HOLD. Reset → BOOT, `pc`=RESET_PC, `drop`=0, `buf_instr`=0.
- BOOT: no request; → REQ next cycle.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. Handshake (`valid&ready`) → WAIT.
- WAIT: await `imem_rsp_valid`.
  - rsp with `drop`=1: discard, clear `drop`, → REQ.
  - rsp with `drop`=0: present combinationally (`if_valid`=1, `if_pc`=`pc`, `if_instr`=`imem_rsp_data`). If `!stall`: `pc`←`pc`+4, → REQ. If `stall`: `buf_instr`←data, → HOLD.
- HOLD: present `buf_instr` at `pc`, `if_valid`=1. On `!stall`: `pc`←`pc`+4, → REQ.
- Redirect (highest priority, any state except BOOT): `pc`←{`redirect_pc`[31:2],2'b00}; `if_valid` forced 0 that cycle; next state REQ, except in WAIT with no response this cycle → stay WAIT with `drop`←1. In REQ, redirect overrides any handshake that cycle: the accepted request (if `ready`=1) is marked stale (→ WAIT, `drop`=1).
- Redirect in WAIT on same cycle as response: response discarded, → REQ, `drop`=0.
- `stall` never blocks a redirect; redirect while stalled in HOLD discards `buf_instr`.
- When `if_valid`=0: `if_pc`=0, `if_instr`=0 (bubble encoding matching an IF/ID flush).
- `pc`+4 wraps modulo 2^32 (FFFF_FFFC → 0000_0000).
- `imem_rsp_valid` outside WAIT is ignored. At most one request outstanding.

## Timing
- Reset values (asserted and first cycle after): `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `if_valid`=0, `if_pc`=0, `if_instr`=0.
- First request: cycle 1 after reset release (BOOT occupies cycle 0).
- Request→response latency: memory-defined, ≥1 cycle after handshake.
- With `ready`=1 and 1-cycle response, no stalls: one instruction every 2 cycles (REQ, WAIT).
- Instruction presented in the WAIT cycle is captured by IF/ID at that cycle's edge when `!stall`; no extra IFU latency.
- `imem_req_addr` stable while `imem_req_valid`=1 and `ready`=0, unless redirect.
- Reset mid-transaction: state→BOOT immediately; late response from before reset ignored (arrives outside WAIT, or memory is reset with the core).

## Test plan
- Reset release, `ready`=1, 1-cycle memory returning addr-derived data → req addrs 8000_0000, 8000_0004, 8000_0008 on cycles 1,3,5; `if_valid` pulses cycles 2,4,6 with matching `if_pc`.
- `stall`=1 for 3 cycles while response arrives at pc 8000_0004 → `if_valid`=1 with same pc/instr held for all 3 cycles and release cycle; no new request until stall drops; next req 8000_0008.
- `ready`=0 for 4 cycles in REQ → `imem_req_valid`=1, addr constant; `if_valid`=0 throughout.
- Redirect to 8000_0103 while in WAIT (response 2 cycles later) → `drop` set, late response discarded (`if_valid`=0), next req addr 8000_0100, its instruction presented with `if_pc`=8000_0100.
- Redirect coincident with valid response and `stall`=1 in HOLD → `if_valid`=0 that cycle, buffer discarded, next req at redirect target.
- Redirect to FFFF_FFFC, no stalls → fetch FFFF_FFFC then 0000_0000.
